grid_renderer: RTL and testbench
================================

// Module: grid_renderer
// PURPOSE
//  Parametrised successor of the life-grid display stage: draws a GRID_W x GRID_H cell field on the MTL2 panel.
//  - Each cell is CELL_PX x CELL_PX pixels.
//  - Contains its own sync/timing generator and clock divider.
//  - Double-buffers the grid in a shadow register loaded once per frame, so the simulation core can update
//    without tearing.
//  - Replaces per-pixel divide/multiply indexing with incremental cell counters.
//  - Sits between the life core (grid, vblank_start) and the panel pins.
// PARAMETERS
//  GRID_W    80        cells per row
//  GRID_H    48        cell rows
//  CELL_PX   10        pixels per cell side, >=2
//  H_ACTIVE  800       visible pixels per line
//  H_FRONT   210       h front porch, pixels
//  H_SYNC    30        h sync width, pixels
//  H_BACK    16        h back porch, pixels (total 1056)
//  V_ACTIVE  480       visible lines
//  V_FRONT   22        v front porch, lines
//  V_SYNC    13        v sync width, lines
//  V_BACK    10        v back porch, lines (total 525)
//  LIVE_RGB  24'hDEDE4D  colour of live cell {R,G,B}
//  DEAD_RGB  24'h000000  colour of dead cell and of area outside the grid
// PORTS
//  clk           in   1              system clock; pixel clock = clk/2
//  reset         in   1              synchronous, active-high
//  grid          in   GRID_W*GRID_H  cell state; bit x + y*GRID_W = cell (x,y), 1 = live
//  vblank_start  out  1              one-clk pulse when the shadow grid is loaded
//  MTL2_DCLK     out  1              pixel clock to panel
//  MTL2_R        out  8              red
//  MTL2_G        out  8              green
//  MTL2_B        out  8              blue
//  MTL2_HSD      out  1              h sync, active-low
//  MTL2_VSD      out  1              v sync, active-low
// BEHAVIOUR
//  - Reset:
//    - pixel-enable toggle=0, MTL2_DCLK=0, hpos=vpos=0, cell/sub counters=0, shadow grid=0.
//    - RGB=0, HSD=VSD=1, vblank_start=0.
//    - Reset mid-frame restarts at pixel (0,0) on the next tick; no partial line is emitted.
//  - Pixel tick pix_ce: asserted every second clk; MTL2_DCLK toggles every clk; all pixel-domain state
//    advances only on pix_ce.
//  - Timing: hpos 0..H_TOTAL-1 wraps to 0 and increments vpos; vpos wraps at V_TOTAL-1.
//    - HSD low for hpos in [H_ACTIVE+H_FRONT, +H_SYNC).
//    - VSD low for vpos in [V_ACTIVE+V_FRONT, +V_SYNC).
//    - display_on = hpos<H_ACTIVE && vpos<V_ACTIVE.
//  - Cell addressing:
//    - sub_x counts 0..CELL_PX-1 in the active region and increments cell_x on wrap; it resets to 0
//      at hpos==0.
//    - sub_y/cell_y do the same per line, resetting at vpos==0.
//    - No divider or multiplier is used.
//    - Row base address is accumulated (+GRID_W per cell row).
//  - Outside-grid pixels (cell_x>=GRID_W or cell_y>=GRID_H, inside display_on) show DEAD_RGB.
//    Blanking outputs RGB=0.
//  - Pipeline: 2 pixel ticks.
//    - Stage 1 registers the cell index and in_grid/display_on.
//    - Stage 2 reads the shadow bit and registers RGB.
//    - HSD/VSD are delayed 2 ticks to stay aligned with RGB.
//  - Shadow load:
//    - On the pix_ce where hpos==0 && vpos==V_ACTIVE, shadow <= grid and vblank_start=1 for that single clk.
//    - grid changes at any other time do not affect the displayed frame.
// CONFIGURATION
//  GRIDLINES_EN defined:
//    - Pixels with sub_x==0 or sub_y==0 inside the grid are drawn 24'h404040 regardless of cell state,
//      giving a 1-px grid overlay.
//    - Same 2-tick latency.
//  GRIDLINES_EN undefined: no overlay; all in-grid pixels show LIVE_RGB/DEAD_RGB by cell state.
// TESTING
//  - Reset:
//    - Hold reset 4 clk.
//    - Required: RGB=0, HSD=VSD=1, vblank_start=0.
//    - Then exactly 2 clk per DCLK period.
//  - Frame timing:
//    - Run 2 frames.
//    - Required: HSD period 2112 clk, low 60 clk; VSD period 1056*525*2 clk, low 13 lines;
//      one vblank_start per frame.
//  - Single cell, grid bit 0 = 1:
//    - Required: pixels (0..9, 0..9) = DE DE 4D, appearing 2 ticks after hpos=0; pixel (10,0) = 00 00 00.
//  - Corner cell:
//    - Set bit 79+47*80.
//    - Required: pixels (790..799, 470..479) live; all other active pixels black.
//  - Tear-free:
//    - Change grid mid-frame (vpos=100).
//    - Required: displayed frame unchanged until after the next vblank_start; next frame shows the new grid.
//  - Reset mid-line at hpos=400:
//    - Required: next tick hpos=0, vpos=0.
//    - GRIDLINES_EN build: all-zero grid shows 404040 at (0,y), (10,y) and (x,0), (x,10); black elsewhere.

Source files
------------

// File: rtl/grid_renderer.sv
// Cell-field renderer for the MTL2 panel: timing generator, pixel-clock divider and a shadow grid loaded once per frame.
// Build macro GRIDLINES_EN draws a 1-px 404040 overlay on the top/left edge of every in-grid cell.
module grid_renderer #(
  parameter int          GRID_W   = 80,
  parameter int          GRID_H   = 48,
  parameter int          CELL_PX  = 10,
  parameter int          H_ACTIVE = 800,
  parameter int          H_FRONT  = 210,
  parameter int          H_SYNC   = 30,
  parameter int          H_BACK   = 16,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FRONT  = 22,
  parameter int          V_SYNC   = 13,
  parameter int          V_BACK   = 10,
  parameter logic [23:0] LIVE_RGB = 24'hDEDE4D,
  parameter logic [23:0] DEAD_RGB = 24'h000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [GRID_W*GRID_H-1:0]   grid,
  output logic                       vblank_start,
  output logic                       MTL2_DCLK,
  output logic [7:0]                 MTL2_R,
  output logic [7:0]                 MTL2_G,
  output logic [7:0]                 MTL2_B,
  output logic                       MTL2_HSD,
  output logic                       MTL2_VSD
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int N_CELLS = GRID_W * GRID_H;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int SUB_W   = $clog2(CELL_PX);
  localparam int CX_W    = $clog2(H_ACTIVE / CELL_PX + 2);
  localparam int CY_W    = $clog2(V_ACTIVE / CELL_PX + 2);
  localparam int CIDX_W  = $clog2(N_CELLS);

  localparam logic [HC_W-1:0]   H_LAST      = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0]   H_ACT       = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]   HS_START    = HC_W'(H_ACTIVE + H_FRONT);
  localparam logic [HC_W-1:0]   HS_END      = HC_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VC_W-1:0]   V_LAST      = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0]   V_ACT       = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]   VS_START    = VC_W'(V_ACTIVE + V_FRONT);
  localparam logic [VC_W-1:0]   VS_END      = VC_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [SUB_W-1:0]  SUB_LAST    = SUB_W'(CELL_PX - 1);
  localparam logic [CX_W-1:0]   GRID_W_CX   = CX_W'(GRID_W);
  localparam logic [CY_W-1:0]   GRID_H_CY   = CY_W'(GRID_H);
  localparam logic [CY_W-1:0]   GRID_H_LAST = CY_W'(GRID_H - 1);
  localparam logic [CIDX_W-1:0] GRID_W_IX   = CIDX_W'(GRID_W);
  localparam logic [23:0]       GRID_RGB    = 24'h404040;

  logic                ce_q, dclk_q, pix_ce;
  logic [HC_W-1:0]     hpos_q, hpos_d;
  logic [VC_W-1:0]     vpos_q, vpos_d;
  logic [SUB_W-1:0]    sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [CX_W-1:0]     cell_x_q, cell_x_d;
  logic [CY_W-1:0]     cell_y_q, cell_y_d;
  logic [CIDX_W-1:0]   row_base_q, row_base_d;
  logic [N_CELLS-1:0]  shadow_q;
  logic                vblank_q, load;

  logic                de_p1, in_grid_p1, hs_p1, vs_p1, gl_p1;
  logic [CIDX_W-1:0]   idx_p1;
  logic [23:0]         rgb_p2;
  logic                hsd_p2, vsd_p2;

  function automatic logic [23:0] pixel_rgb(input logic de, input logic in_grid,
                                            input logic live, input logic line);
    logic [23:0] c;
    c = 24'h000000;
    if (de) c = DEAD_RGB;
    if (de && in_grid) c = line ? GRID_RGB : (live ? LIVE_RGB : DEAD_RGB);
    return c;
  endfunction

  assign pix_ce = ce_q;
  assign load   = pix_ce && (hpos_q == '0) && (vpos_q == V_ACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q   <= 1'b0;
      dclk_q <= 1'b0;
    end else begin
      ce_q   <= ~ce_q;
      dclk_q <= ~dclk_q;
    end
  end

  // Incremental cell addressing: sub counters wrap at CELL_PX, row base steps by GRID_W.
  always_comb begin
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;
    sub_x_d    = sub_x_q;
    cell_x_d   = cell_x_q;
    sub_y_d    = sub_y_q;
    cell_y_d   = cell_y_q;
    row_base_d = row_base_q;
    if (pix_ce) begin
      if (hpos_q == H_LAST) begin
        hpos_d   = '0;
        sub_x_d  = '0;
        cell_x_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d     = '0;
          sub_y_d    = '0;
          cell_y_d   = '0;
          row_base_d = '0;
        end else begin
          vpos_d = vpos_q + 1'b1;
          if (vpos_q < V_ACT) begin
            if (sub_y_q == SUB_LAST) begin
              sub_y_d  = '0;
              cell_y_d = cell_y_q + 1'b1;
              if (cell_y_q < GRID_H_LAST) row_base_d = row_base_q + GRID_W_IX;
            end else begin
              sub_y_d = sub_y_q + 1'b1;
            end
          end
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
        if (hpos_q < H_ACT) begin
          if (sub_x_q == SUB_LAST) begin
            sub_x_d  = '0;
            cell_x_d = cell_x_q + 1'b1;
          end else begin
            sub_x_d = sub_x_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos_q     <= '0;
      vpos_q     <= '0;
      sub_x_q    <= '0;
      cell_x_q   <= '0;
      sub_y_q    <= '0;
      cell_y_q   <= '0;
      row_base_q <= '0;
      shadow_q   <= '0;
      vblank_q   <= 1'b0;
    end else begin
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
      sub_x_q    <= sub_x_d;
      cell_x_q   <= cell_x_d;
      sub_y_q    <= sub_y_d;
      cell_y_q   <= cell_y_d;
      row_base_q <= row_base_d;
      vblank_q   <= load;
      if (load) shadow_q <= grid;
    end
  end

  // Stage 1: cell index, region flags and raw syncs.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_p1      <= 1'b0;
      in_grid_p1 <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
    end else if (pix_ce) begin
      de_p1      <= (hpos_q < H_ACT) && (vpos_q < V_ACT);
      in_grid_p1 <= (cell_x_q < GRID_W_CX) && (cell_y_q < GRID_H_CY);
      hs_p1      <= !((hpos_q >= HS_START) && (hpos_q < HS_END));
      vs_p1      <= !((vpos_q >= VS_START) && (vpos_q < VS_END));
    end
  end

  always_ff @(posedge clk) begin
    if (pix_ce) begin
      idx_p1 <= row_base_q + CIDX_W'(cell_x_q);
`ifdef GRIDLINES_EN
      gl_p1  <= (sub_x_q == '0) || (sub_y_q == '0);
`else
      gl_p1  <= 1'b0;
`endif
    end
  end

  // Stage 2: shadow lookup and colour, syncs aligned with RGB.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_p2 <= '0;
      hsd_p2 <= 1'b1;
      vsd_p2 <= 1'b1;
    end else if (pix_ce) begin
      rgb_p2 <= pixel_rgb(de_p1, in_grid_p1, shadow_q[idx_p1], gl_p1);
      hsd_p2 <= hs_p1;
      vsd_p2 <= vs_p1;
    end
  end

  assign vblank_start = vblank_q;
  assign MTL2_DCLK    = dclk_q;
  assign MTL2_R       = rgb_p2[23:16];
  assign MTL2_G       = rgb_p2[15:8];
  assign MTL2_B       = rgb_p2[7:0];
  assign MTL2_HSD     = hsd_p2;
  assign MTL2_VSD     = vsd_p2;

endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer on a reduced panel (40x24 active, 7x4 cells of 5 px) so whole frames are cheap.
module tb_grid_renderer;

  localparam int GRID_W = 7, GRID_H = 4, CELL_PX = 5;
  localparam int H_ACTIVE = 40, H_FRONT = 6, H_SYNC = 4, H_BACK = 4;
  localparam int V_ACTIVE = 24, V_FRONT = 3, V_SYNC = 2, V_BACK = 2;
  localparam int H_TOTAL = 54, V_TOTAL = 31;
  localparam int NC = GRID_W * GRID_H;
  localparam logic [23:0] LIVE = 24'hDEDE4D;
`ifdef GRIDLINES_EN
  localparam logic [23:0] GL   = 24'h404040;
  localparam logic [23:0] GL_L = 24'h404040;
`else
  localparam logic [23:0] GL   = 24'h000000;
  localparam logic [23:0] GL_L = 24'hDEDE4D;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NC-1:0] grid = '0;
  logic          vblank_start, MTL2_DCLK, MTL2_HSD, MTL2_VSD;
  logic [7:0]    MTL2_R, MTL2_G, MTL2_B;

  int n_checks = 0;
  int n_fails  = 0;
  logic [23:0] snap [0:V_ACTIVE-1][0:H_ACTIVE-1];

  grid_renderer #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_PX(CELL_PX),
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .clk(clk), .reset(reset), .grid(grid), .vblank_start(vblank_start),
    .MTL2_DCLK(MTL2_DCLK), .MTL2_R(MTL2_R), .MTL2_G(MTL2_G), .MTL2_B(MTL2_B),
    .MTL2_HSD(MTL2_HSD), .MTL2_VSD(MTL2_VSD)
  );

  always #5 clk = ~clk;

  // Edge/pulse measurement in clk cycles, sampled on the falling edge.
  int   cyc = 0, hs_fall = -1, vs_fall = -1;
  int   hs_period = 0, hs_low = 0, vs_period = 0, vs_low = 0, vbl_cnt = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;
  always @(negedge clk) begin
    cyc     <= cyc + 1;
    hs_prev <= MTL2_HSD;
    vs_prev <= MTL2_VSD;
    if (vblank_start) vbl_cnt <= vbl_cnt + 1;
    if (hs_prev && !MTL2_HSD) begin
      if (hs_fall >= 0) hs_period <= cyc - hs_fall;
      hs_fall <= cyc;
    end
    if (!hs_prev && MTL2_HSD && hs_fall >= 0) hs_low <= cyc - hs_fall;
    if (vs_prev && !MTL2_VSD) begin
      if (vs_fall >= 0) vs_period <= cyc - vs_fall;
      vs_fall <= cyc;
    end
    if (!vs_prev && MTL2_VSD && vs_fall >= 0) vs_low <= cyc - vs_fall;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int x, input int y, input logic [NC-1:0] g);
    int cx, cy;
    if (x >= H_ACTIVE || y >= V_ACTIVE) return 24'h000000;
    cx = x / CELL_PX;
    cy = y / CELL_PX;
    if (cx >= GRID_W || cy >= GRID_H) return 24'h000000;
`ifdef GRIDLINES_EN
    if ((x % CELL_PX) == 0 || (y % CELL_PX) == 0) return 24'h404040;
`endif
    return g[cx + cy * GRID_W] ? LIVE : 24'h000000;
  endfunction

  task automatic reset_dut(input string tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk({tag, "_rgb"}, {MTL2_R, MTL2_G, MTL2_B}, 0);
    chk({tag, "_hsd"}, MTL2_HSD, 1);
    chk({tag, "_vsd"}, MTL2_VSD, 1);
    chk({tag, "_vblank"}, vblank_start, 0);
    chk({tag, "_dclk"}, MTL2_DCLK, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_dclk_hi"}, MTL2_DCLK, 1);
    @(posedge clk); #1;
    chk({tag, "_dclk_lo"}, MTL2_DCLK, 0);
    chk({tag, "_blank_start"}, {MTL2_R, MTL2_G, MTL2_B}, 0);
  endtask

  // Walks one full frame pixel by pixel; the first sample lands on pixel (0,0).
  task automatic scan_frame(input string tag, input logic [NC-1:0] shown,
                            input int chg_v, input logic [NC-1:0] newg);
    int pix_err, sync_err;
    logic [23:0] rgb;
    logic hs_ex, vs_ex;
    pix_err = 0;
    sync_err = 0;
    for (int v = 0; v < V_TOTAL; v++) begin
      for (int h = 0; h < H_TOTAL; h++) begin
        if (h == 0 && v == chg_v) grid = newg;
        repeat (2) @(posedge clk);
        #1;
        rgb = {MTL2_R, MTL2_G, MTL2_B};
        if (h < H_ACTIVE && v < V_ACTIVE) snap[v][h] = rgb;
        hs_ex = !(h >= H_ACTIVE + H_FRONT && h < H_ACTIVE + H_FRONT + H_SYNC);
        vs_ex = !(v >= V_ACTIVE + V_FRONT && v < V_ACTIVE + V_FRONT + V_SYNC);
        if (rgb !== exp_pix(h, v, shown)) pix_err++;
        if (MTL2_HSD !== hs_ex || MTL2_VSD !== vs_ex) sync_err++;
      end
    end
    chk({tag, "_pixel_errs"}, pix_err, 0);
    chk({tag, "_sync_errs"}, sync_err, 0);
  endtask

  logic [NC-1:0] g_single, g_corner;
  int vbl0;

  initial begin
    g_single = '0;
    g_single[0] = 1'b1;
    g_corner = '0;
    g_corner[6 + 3 * GRID_W] = 1'b1;
    grid = g_single;

    reset_dut("rst");
    scan_frame("frameA", '0, -1, '0);
    chk("A_gl_0_7", snap[7][0], GL);
    chk("A_gl_5_7", snap[7][5], GL);
    chk("A_gl_7_0", snap[0][7], GL);
    chk("A_gl_7_5", snap[5][7], GL);
    chk("A_7_7", snap[7][7], 0);
    chk("A_outside_35_0", snap[0][35], 0);

    scan_frame("frameB", g_single, -1, '0);
    chk("B_0_0", snap[0][0], GL_L);
    chk("B_1_1", snap[1][1], LIVE);
    chk("B_4_4", snap[4][4], LIVE);
    chk("B_4_1", snap[1][4], LIVE);
    chk("B_5_0", snap[0][5], GL);
    chk("B_6_1", snap[1][6], 0);
    chk("B_1_6", snap[6][1], 0);
    chk("B_36_1", snap[1][36], 0);

    vbl0 = vbl_cnt;
    scan_frame("frameC_tear", g_single, 10, g_corner);
    chk("C_31_16_old", snap[16][31], 0);
    chk("C_1_1_old", snap[1][1], LIVE);
    scan_frame("frameD", g_corner, -1, '0);
    chk("vblank_per_frame", vbl_cnt - vbl0, 2);
    chk("D_31_16", snap[16][31], LIVE);
    chk("D_34_19", snap[19][34], LIVE);
    chk("D_30_17", snap[17][30], GL_L);
    chk("D_29_16", snap[16][29], 0);
    chk("D_35_19", snap[19][35], 0);
    chk("D_34_20", snap[20][34], 0);
    chk("D_1_1", snap[1][1], 0);

    chk("hsd_period_clk", hs_period, 2 * H_TOTAL);
    chk("hsd_low_clk", hs_low, 2 * H_SYNC);
    chk("vsd_period_clk", vs_period, 2 * H_TOTAL * V_TOTAL);
    chk("vsd_low_clk", vs_low, 2 * H_TOTAL * V_SYNC);

    repeat (2 * (2 * H_TOTAL + 20)) @(posedge clk);
    reset_dut("midrst");
    vbl0 = vbl_cnt;
    scan_frame("frameF", '0, -1, '0);
    chk("F_31_16_cleared", snap[16][31], 0);
    scan_frame("frameG", g_corner, -1, '0);
    chk("G_31_16", snap[16][31], LIVE);
    chk("vblank_after_reset", vbl_cnt - vbl0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
